// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the hazard sequencer and the pipeline / data memory.
// The sequencer side is the master; the pipeline and memory side is the slave.
interface pipe_hazard_ctrl_if #(
    parameter int LANES = 4,
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    localparam int BEAT_W = $clog2(LANES);

    logic               id_valid;
    logic [REG_W-1:0]   id_rs1;
    logic [REG_W-1:0]   id_rs2;
    logic               id_use_rs1;
    logic               id_use_rs2;
    logic [1:0]         ex_wb;
    logic [REG_W-1:0]   ex_dest;
    logic               ex_branch_taken;
    logic               mem_vmem;
    logic               mem_req;
    logic               mem_ack;
    logic [BEAT_W-1:0]  beat_idx;
    logic               pc_en;
    logic               ifid_en;
    logic               ifid_flush;
    logic               idex_en;
    logic               idex_flush;
    logic               exmem_en;
    logic               memwb_en;
    logic [CNT_W-1:0]   stall_cycles;

    modport master (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_wb, ex_dest, ex_branch_taken, mem_vmem, mem_ack,
        output mem_req, beat_idx, pc_en, ifid_en, ifid_flush,
        output idex_en, idex_flush, exmem_en, memwb_en, stall_cycles
    );

    modport slave (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_wb, ex_dest, ex_branch_taken, mem_vmem, mem_ack,
        input  mem_req, beat_idx, pc_en, ifid_en, ifid_flush,
        input  idex_en, idex_flush, exmem_en, memwb_en, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage vector pipeline: load-use stalls, branch
// flushes, multi-beat vector memory sequencing and a saturating stall counter.
module pipe_hazard_ctrl #(
    parameter int LANES = 4,
    parameter int REG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    pipe_hazard_ctrl_if.master  bus
);
    localparam int BEAT_W = $clog2(LANES);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LANES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        VMEM = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [BEAT_W-1:0]  beat_r;
    logic [BEAT_W-1:0]  beat_nxt_s;
    logic [CNT_W-1:0]   stall_r;

    logic hazard_s;
    logic last_beat_s;
    logic stall_cnt_s;
    logic mem_req_s;
    logic pc_en_s;
    logic ifid_en_s;
    logic ifid_flush_s;
    logic idex_en_s;
    logic idex_flush_s;
    logic exmem_en_s;
    logic memwb_en_s;

    function automatic logic rs_match(
        input logic             use_rs,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] dest
    );
        return use_rs & (rs == dest);
    endfunction

    // Load-use hazard: the instruction in ID needs a register the load in EX is about to fetch.
    always_comb begin
        hazard_s = bus.id_valid & bus.ex_wb[0] & bus.ex_wb[1] &
                   (rs_match(bus.id_use_rs1, bus.id_rs1, bus.ex_dest) |
                    rs_match(bus.id_use_rs2, bus.id_rs2, bus.ex_dest));
    end

    // Final beat of a vector access is the acknowledged beat on the last lane.
    always_comb begin
        last_beat_s = bus.mem_ack & (beat_r == LAST_BEAT);
    end

    // Next state, beat sequencing and pipeline-register controls.
    always_comb begin
        state_nxt_s  = state_r;
        beat_nxt_s   = beat_r;
        mem_req_s    = 1'b0;
        pc_en_s      = 1'b1;
        ifid_en_s    = 1'b1;
        ifid_flush_s = 1'b0;
        idex_en_s    = 1'b1;
        idex_flush_s = 1'b0;
        exmem_en_s   = 1'b1;
        memwb_en_s   = 1'b1;
        // Reset overrides the inputs so no stray request reaches memory while held.
        if (!rst_n) begin
            state_nxt_s = RUN;
            beat_nxt_s  = {BEAT_W{1'b0}};
        end else begin
            case (state_r)
                RUN: begin
                    if (bus.mem_vmem) begin
                        mem_req_s   = 1'b1;
                        pc_en_s     = 1'b0;
                        ifid_en_s   = 1'b0;
                        idex_en_s   = 1'b0;
                        exmem_en_s  = 1'b0;
                        memwb_en_s  = 1'b0;
                        state_nxt_s = VMEM;
                        beat_nxt_s  = bus.mem_ack ? BEAT_W'(1) : {BEAT_W{1'b0}};
                    end else if (bus.ex_branch_taken) begin
                        // The stalled instruction would be discarded anyway, so no stall.
                        ifid_flush_s = 1'b1;
                        idex_flush_s = 1'b1;
                    end else if (hazard_s) begin
                        pc_en_s      = 1'b0;
                        ifid_en_s    = 1'b0;
                        idex_flush_s = 1'b1;
                    end else begin
                        mem_req_s = 1'b0;
                    end
                end
                VMEM: begin
                    mem_req_s = 1'b1;
                    if (last_beat_s) begin
                        state_nxt_s = RUN;
                        beat_nxt_s  = {BEAT_W{1'b0}};
                    end else begin
                        pc_en_s    = 1'b0;
                        ifid_en_s  = 1'b0;
                        idex_en_s  = 1'b0;
                        exmem_en_s = 1'b0;
                        memwb_en_s = 1'b0;
                        if (bus.mem_ack) begin
                            beat_nxt_s = beat_r + BEAT_W'(1);
                        end else begin
                            beat_nxt_s = beat_r;
                        end
                    end
                end
                default: begin
                    state_nxt_s = RUN;
                    beat_nxt_s  = {BEAT_W{1'b0}};
                end
            endcase
        end
    end

    // Every vector-access cycle counts, including the acknowledged final beat that releases the pipe.
    always_comb begin
        stall_cnt_s = ~pc_en_s | (state_r == VMEM);
    end

    // FSM state and beat index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RUN;
            beat_r  <= {BEAT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            beat_r  <= beat_nxt_s;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_r <= {CNT_W{1'b0}};
        end else if (stall_cnt_s && (stall_r != CNT_MAX)) begin
            stall_r <= stall_r + CNT_W'(1);
        end else begin
            stall_r <= stall_r;
        end
    end

    assign bus.mem_req      = mem_req_s;
    assign bus.beat_idx     = beat_r;
    assign bus.pc_en        = pc_en_s;
    assign bus.ifid_en      = ifid_en_s;
    assign bus.ifid_flush   = ifid_flush_s;
    assign bus.idex_en      = idex_en_s;
    assign bus.idex_flush   = idex_flush_s;
    assign bus.exmem_en     = exmem_en_s;
    assign bus.memwb_en     = memwb_en_s;
    assign bus.stall_cycles = stall_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_pipe_hazard_ctrl;
    localparam logic [6:0] EN = 7'b1101011;
    localparam logic [6:0] LU = 7'b0001111;
    localparam logic [6:0] BR = 7'b1111111;
    localparam logic [6:0] FZ = 7'b0000000;

    typedef struct {
        logic [25:0] v;
        string       name;
    } exp_t;

    logic clk;
    logic rst_n;
    logic rst_sat_n;
    int   checks;
    int   failures;
    logic done;
    logic end_checked;

    exp_t        exp_q[$];
    logic [3:0]  sat_q[$];
    exp_t        e_m;
    logic [25:0] act_m;
    logic [3:0]  sat_m;

    pipe_hazard_ctrl_if #(.LANES(4), .REG_W(4), .CNT_W(16)) bus ();
    pipe_hazard_ctrl_if #(.LANES(4), .REG_W(4), .CNT_W(4))  bus_s ();

    pipe_hazard_ctrl #(.LANES(4), .REG_W(4), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    pipe_hazard_ctrl #(.LANES(4), .REG_W(4), .CNT_W(4)) dut_sat (
        .clk   (clk),
        .rst_n (rst_sat_n),
        .bus   (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int rst, input int idv, input int rs1, input int rs2,
                        input int u1, input int u2, input int wb, input int dest,
                        input int br, input int vm, input int ack,
                        input int req, input int beat, input logic [6:0] ctl,
                        input int stall, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n               = 1'(rst);
        bus.id_valid        = 1'(idv);
        bus.id_rs1          = 4'(rs1);
        bus.id_rs2          = 4'(rs2);
        bus.id_use_rs1      = 1'(u1);
        bus.id_use_rs2      = 1'(u2);
        bus.ex_wb           = 2'(wb);
        bus.ex_dest         = 4'(dest);
        bus.ex_branch_taken = 1'(br);
        bus.mem_vmem        = 1'(vm);
        bus.mem_ack         = 1'(ack);
        e.v    = {1'(req), 2'(beat), ctl, 16'(stall)};
        e.name = name;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e_m   = exp_q.pop_front();
            act_m = {bus.mem_req, bus.beat_idx, bus.pc_en, bus.ifid_en, bus.ifid_flush,
                     bus.idex_en, bus.idex_flush, bus.exmem_en, bus.memwb_en, bus.stall_cycles};
            checks = checks + 1;
            if (act_m !== e_m.v) begin
                failures = failures + 1;
                $display("FAIL %s: actual req/beat/ctl/stall=%b/%0d/%b/%0d required=%b/%0d/%b/%0d",
                         e_m.name, act_m[25], act_m[24:23], act_m[22:16], act_m[15:0],
                         e_m.v[25], e_m.v[24:23], e_m.v[22:16], e_m.v[15:0]);
            end
        end
        if (sat_q.size() != 0) begin
            sat_m  = sat_q.pop_front();
            checks = checks + 1;
            if (bus_s.stall_cycles !== sat_m) begin
                failures = failures + 1;
                $display("FAIL sat_stall: actual=%0d required=%0d", bus_s.stall_cycles, sat_m);
            end
        end
        if (done && !end_checked) begin
            end_checked = 1'b1;
            checks      = checks + 1;
            if (exp_q.size() != 0 || sat_q.size() != 0) begin
                failures = failures + 1;
                $display("FAIL drain: actual pending=%0d required=0", exp_q.size() + sat_q.size());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0; failures = 0; done = 1'b0; end_checked = 1'b0;
        rst_n = 1'b0; rst_sat_n = 1'b0;
        bus.id_valid = 1'b0; bus.id_rs1 = 4'd0; bus.id_rs2 = 4'd0;
        bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0; bus.ex_wb = 2'b00;
        bus.ex_dest = 4'd0; bus.ex_branch_taken = 1'b0; bus.mem_vmem = 1'b0; bus.mem_ack = 1'b0;
        bus_s.id_valid = 1'b0; bus_s.id_rs1 = 4'd0; bus_s.id_rs2 = 4'd0;
        bus_s.id_use_rs1 = 1'b0; bus_s.id_use_rs2 = 1'b0; bus_s.ex_wb = 2'b00;
        bus_s.ex_dest = 4'd0; bus_s.ex_branch_taken = 1'b0; bus_s.mem_vmem = 1'b1; bus_s.mem_ack = 1'b0;

        // rst idv rs1 rs2 u1 u2 wb dest br vm ack | req beat ctl stall
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, EN, 0, "reset_gate_vmem");
        step(0, 1, 5, 5, 1, 1, 3, 5, 1, 0, 0,  0, 0, EN, 0, "reset_gate_hazard");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, EN, 0, "reset_release");
        step(1, 1, 0, 5, 0, 1, 3, 5, 0, 0, 0,  0, 0, LU, 0, "loaduse_rs2");
        step(1, 1, 0, 5, 0, 1, 0, 5, 0, 0, 0,  0, 0, EN, 1, "loaduse_cleared");
        step(1, 1, 3, 5, 1, 1, 1, 3, 0, 0, 0,  0, 0, EN, 1, "alu_write_no_stall");
        step(1, 1, 3, 5, 0, 1, 3, 3, 0, 0, 0,  0, 0, EN, 1, "rs1_unused_no_stall");
        step(1, 1, 3, 5, 1, 0, 3, 3, 0, 0, 0,  0, 0, LU, 1, "loaduse_rs1");
        step(1, 0, 3, 3, 1, 1, 3, 3, 0, 0, 0,  0, 0, EN, 2, "id_invalid_no_stall");
        step(1, 1, 7, 7, 1, 1, 3, 7, 1, 0, 0,  0, 0, BR, 2, "branch_over_hazard");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, EN, 2, "branch_no_stall_count");
        // Vector load with branch and hazard also present; acks on cycles 2,4,5,7.
        step(1, 1, 7, 7, 1, 1, 3, 7, 1, 1, 0,  1, 0, FZ, 2, "vmem_priority_c0");
        step(1, 1, 7, 7, 1, 1, 3, 7, 1, 1, 0,  1, 0, FZ, 3, "vmem_c1");
        step(1, 1, 7, 7, 1, 1, 3, 7, 1, 1, 1,  1, 0, FZ, 4, "vmem_c2_ack");
        step(1, 1, 7, 7, 1, 1, 3, 7, 1, 1, 0,  1, 1, FZ, 5, "vmem_c3");
        step(1, 1, 7, 7, 1, 1, 3, 7, 1, 1, 1,  1, 1, FZ, 6, "vmem_c4_ack");
        step(1, 1, 7, 7, 1, 1, 3, 7, 1, 1, 1,  1, 2, FZ, 7, "vmem_c5_ack");
        step(1, 1, 7, 7, 1, 1, 3, 7, 1, 1, 0,  1, 3, FZ, 8, "vmem_c6");
        step(1, 1, 7, 7, 1, 1, 3, 7, 1, 1, 1,  1, 3, EN, 9, "vmem_last_beat_release");
        step(1, 1, 7, 7, 1, 1, 3, 7, 1, 0, 0,  0, 0, BR, 10, "branch_after_release");
        // Ack in the entry cycle, then reset after two acks.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  1, 0, FZ, 10, "vmem_ack_entry");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 1, FZ, 11, "vmem_b1_wait");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  1, 1, FZ, 12, "vmem_b1_ack");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, EN, 0, "reset_mid_vmem");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, EN, 0, "reset_hold");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 0, FZ, 0, "vmem_restart_beat0");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  1, 0, FZ, 1, "restart_ack0");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  1, 1, FZ, 2, "restart_ack1");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  1, 2, FZ, 3, "restart_ack2");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  1, 3, EN, 4, "restart_last_beat");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, EN, 5, "ack_ignored_idle");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, EN, 5, "idle_beat_still0");

        // Saturation: 4-bit counter held in VMEM with no acks.
        for (int k = 0; k < 22; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) rst_sat_n = 1'b1;
            sat_q.push_back((k > 15) ? 4'd15 : 4'(k));
        end

        @(posedge clk);
        done = 1'b1;
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage vector pipeline.
- Drives the enable and flush controls of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers.
- Detects load-use hazards and taken branches.
- Sequences multi-beat vector memory accesses (one beat per lane) through a req/ack handshake with data memory, freezing the pipeline until the last beat completes.
- Keeps a saturating count of stall cycles for performance monitoring.

Parameters:
- LANES, 4: beats per vector memory operation; must be ≥2 and a power of 2.
- REG_W, 4: width of register specifiers.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  system clock; FSM and counters update on posedge; pipeline registers capture on negedge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a valid instruction.
- id_rs1  in  REG_W  ID source register 1.
- id_rs2  in  REG_W  ID source register 2.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_wb  in  2  ID_EX wb field: bit0 = register write, bit1 = result from memory (load).
- ex_dest  in  REG_W  ID_EX destination register.
- ex_branch_taken  in  1  branch resolved taken in EX.
- mem_vmem  in  1  EX_MEM holds a vector load/store.
- mem_req  out  1  memory beat request.
- mem_ack  in  1  memory beat completed.
- beat_idx  out  log2(LANES)  lane index of the current beat.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF_ID capture enable.
- ifid_flush  out  1  IF_ID load bubble.
- idex_en  out  1  ID_EX capture enable.
- idex_flush  out  1  ID_EX load bubble.
- exmem_en  out  1  EX_MEM capture enable.
- memwb_en  out  1  MEM_WB capture enable.
- stall_cycles  out  CNT_W  saturating stall-cycle count.

Behaviour:
- States: RUN, VMEM. State, beat_idx and stall_cycles are registered on posedge clk.
- All control outputs are combinational from state and current inputs. They are therefore stable across the following negedge capture.
- Reset (asynchronous, any time including mid-VMEM):
  - state=RUN, beat_idx=0, stall_cycles=0.
  - While reset is asserted: mem_req=0, all *_en=1, all *_flush=0.
  - A partially transferred vector op is abandoned; the next request restarts at beat 0.
- Priority in RUN: vector memory > branch flush > load-use stall.
- RUN, mem_vmem=1:
  - All *_en=0, flushes=0, mem_req=1, beat_idx=0.
  - Next state is VMEM. If mem_ack=1 in this same cycle, beat_idx advances to 1.
- RUN, ex_branch_taken=1 (mem_vmem=0):
  - All *_en=1, ifid_flush=1, idex_flush=1.
  - A simultaneous load-use hazard is ignored because the stalled instruction is discarded.
- RUN, load-use hazard:
  - Hazard condition: id_valid & ex_wb[0] & ex_wb[1] & ((id_use_rs1 & id_rs1==ex_dest) | (id_use_rs2 & id_rs2==ex_dest)).
  - Response: pc_en=0, ifid_en=0, idex_flush=1; exmem_en=memwb_en=1; idex_en=1 so the bubble is captured.
  - Lasts exactly one cycle. The load then sits in EX_MEM, and the datapath forwards its data from MEM_WB.
- RUN, otherwise: all *_en=1, flushes=0, mem_req=0.
- VMEM:
  - mem_req=1 and all *_en=0.
  - Each posedge with mem_ack=1 increments beat_idx.
  - mem_ack sampled while mem_req=0 is ignored.
- VMEM, final beat (mem_ack=1 and beat_idx==LANES-1):
  - All *_en=1 in that same cycle.
  - Next state RUN, beat_idx wraps to 0.
- VMEM: ex_branch_taken and the hazard inputs are ignored; they are re-evaluated after release.
- stall_cycles increments by 1 on every posedge where pc_en=0, i.e. load-use stalls and VMEM cycles, including a VMEM cycle that is acknowledged.
- stall_cycles saturates at 2^CNT_W-1 and never wraps.

Test Plan:
- Reset values: hold rst_n=0, then release with no hazards → all enables 1, flushes 0, mem_req 0, beat_idx 0, stall_cycles 0.
- Load-use: ex_wb=2'b11, ex_dest=5, id_valid=1, id_use_rs2=1, id_rs2=5 → one cycle with pc_en=0, ifid_en=0, idex_flush=1; then hazard clears; stall_cycles=1.
- Vector load, LANES=4, with mem_ack pulsed on cycles 2, 4, 5, 7 after mem_vmem=1 → mem_req high for 8 cycles; beat_idx steps 0→1→2→3; enables return to 1 on the cycle of the 4th ack; stall_cycles=8.
- Simultaneous events: mem_vmem=1, ex_branch_taken=1 and load-use hazard all in the same cycle → VMEM taken; no flush asserted until release.
- Branch plus hazard: ex_branch_taken=1 with a load-use match → ifid_flush=idex_flush=1, pc_en=1, stall_cycles unchanged.
- Reset mid-VMEM: assert rst_n=0 after 2 of 4 acks → mem_req drops immediately; beat_idx=0; after release, mem_vmem=1 restarts at beat 0.
- Saturation: with CNT_W=4, sustain 20 stall cycles → stall_cycles holds at 15.
